seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring divider for the eight-bit four-function calculator; the inverse of the add/multiply path.
- Sits beside the carry-lookahead adder in the arithmetic unit and is selected by the operation decoder for the divide function.
- Accepts a start request, computes quotient and remainder one bit per clock, and reports completion with a single-cycle done pulse.
- Supports unsigned and two's-complement operands; signed results truncate toward zero.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while a division is in progress (CALC, FIX)
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result quotient, held until next done
- remainder  output  WIDTH  result remainder, held until next done
- div_by_zero  output  1  divisor was zero; held with results
- ovr  output  1  signed overflow (most-negative / -1); held with results

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset (asynchronous, any state): state = IDLE; busy, done, quotient, remainder, div_by_zero, ovr all 0; iteration counter 0. Assertion mid-operation aborts the division and discards partial results.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on an edge with start=1:
  - divisor != 0: capture operand magnitudes (negate negative operands when signed_mode=1), record quotient sign (sign xor) and remainder sign (dividend sign), clear the partial remainder, load counter = WIDTH, go to CALC.
  - divisor == 0: go to DONE directly, loading quotient = all ones, remainder = dividend, div_by_zero = 1, ovr = 0.
- CALC: each edge shifts {partial remainder, dividend magnitude} left by 1, then trial-subtracts the divisor magnitude (WIDTH+1-bit subtract). If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0. The counter decrements each edge; after WIDTH edges, go to FIX.
- FIX: apply signs:
  - Negate the quotient if its sign is 1.
  - Negate the remainder if the dividend was negative.
  - ovr = signed_mode AND dividend == 100..0 AND divisor == all ones.
  - Register quotient, remainder, ovr; div_by_zero = 0; go to DONE.
- DONE: done = 1 for exactly this cycle; unconditionally return to IDLE on the next edge.
- Latency: for nonzero divisor, done is high WIDTH+1 cycles after the edge that samples start (9 for WIDTH=8). For divide-by-zero, done is high in the cycle after that edge.
- busy = 1 in CALC and FIX; 0 in IDLE and DONE.
- start in CALC, FIX or DONE is ignored (not queued). Back-to-back operation: start may be asserted in the cycle after done.
- Operands are captured at acceptance; input changes afterwards have no effect.
- Outputs quotient, remainder, div_by_zero and ovr change only on the edge entering DONE (or on reset).
- Overflow case (signed, most-negative / -1): the magnitude result wraps, giving quotient = 100..0 (e.g. 0x80), remainder = 0, ovr = 1.
- Unsigned mode: ovr is always 0.
- Invariants:
  - Unsigned, divisor != 0: dividend = quotient*divisor + remainder, remainder < divisor.
  - Signed, no overflow: |remainder| < |divisor|, and the remainder takes the dividend's sign or is 0.

Test Plan:
- Unsigned 100/7, start for one cycle → busy high 8+1 cycles; done pulse 9 cycles after start; quotient=14 (0x0E), remainder=2, div_by_zero=0, ovr=0.
- Signed -100/7 (0x9C/0x07) → quotient=0xF2 (-14), remainder=0xFE (-2); signed 100/-7 → 0xF2 and 0x02; unsigned 255/1 → 255, 0.
- Divisor 0, dividend 0x5A, either mode → done one cycle after start; quotient=0xFF, remainder=0x5A, div_by_zero=1, busy never high.
- Signed 0x80/0xFF → quotient=0x80, remainder=0, ovr=1. The same operands unsigned (128/255) → quotient 0, remainder 128, ovr=0.
- Start pulsed again mid-CALC with different operands → ignored; first result unchanged and a single done pulse. Start in the cycle after done → accepted, with a second done 9 cycles later.
- rst_n dropped during the 4th CALC cycle → all outputs 0 immediately, with no done pulse. After release, a new 20/3 → 6 and 2 with normal latency.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned
// operands, results held from the done pulse until the next completed division.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovr
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only while idle; done is a one-cycle pulse in
    // the DONE state and the result outputs are valid from that cycle onward.
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
    logic             q_neg_q, r_neg_q, ovr_pend_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q, ovr_q;

    logic             a_neg, b_neg, div_zero, ovr_cond;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_ok;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        a_neg    = signed_mode & dividend[WIDTH-1];
        b_neg    = signed_mode & divisor[WIDTH-1];
        a_mag    = a_neg ? (-dividend) : dividend;
        b_mag    = b_neg ? (-divisor) : divisor;
        div_zero = (divisor == '0);
        ovr_cond = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
        // Top bit of the (WIDTH+1)-bit difference is the borrow: set means restore.
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        trial_ok = ~trial[WIDTH];
        q_fix    = q_neg_q ? (-dvd_q) : dvd_q;
        r_fix    = r_neg_q ? (-rem_q) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = div_zero ? DONE : CALC;
            CALC: if (cnt_q == CW'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ovr_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && div_zero) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend;
                        dbz_q       <= 1'b1;
                        ovr_q       <= 1'b0;
                    end else if (start) begin
                        dvd_q      <= a_mag;
                        dvs_q      <= b_mag;
                        rem_q      <= '0;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        ovr_pend_q <= ovr_cond;
                        cnt_q      <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    // dvd_q doubles as the quotient: dividend bits shift out, quotient bits shift in.
                    rem_q <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], trial_ok};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
                    dbz_q       <= 1'b0;
                    ovr_q       <= ovr_pend_q;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign ovr         = ovr_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed results, latency, busy span,
// ignored mid-operation start, back-to-back operation and mid-operation reset.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       ovr;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovr         (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start presented in the current (idle) cycle; the next edge accepts it.
    task automatic do_div(input string name, input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                          input logic eovr, input int poke_at);
        int n;
        int nbusy;
        int exp_lat;
        exp_lat     = edbz ? 0 : 9;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        nbusy = 0;
        while (!done && n < 30) begin
            if (busy) nbusy++;
            if (n == poke_at) begin
                start       = 1'b1;
                dividend    = 8'h10;
                divisor     = 8'h03;
                signed_mode = ~sm;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy_cycles"}, nbusy, exp_lat);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_div_by_zero"}, div_by_zero, edbz);
        check({name, "_ovr"}, ovr, eovr);
        @(posedge clk); #1;
        check({name, "_done_single"}, done, 0);
        check({name, "_quotient_held"}, quotient, eq);
    endtask

    initial begin
        int ndone;
        rst_n       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovr", ovr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_div("u100_7",      1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0, -1);
        do_div("s_m100_7",    1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, -1);
        do_div("s_100_m7",    1'b1, 8'h64,  8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, -1);
        do_div("u255_1",      1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, -1);
        do_div("u_dbz",       1'b0, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1'b1, 1'b0, -1);
        do_div("s_dbz",       1'b1, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1'b1, 1'b0, -1);
        do_div("u0_5",        1'b0, 8'h00,  8'h05, 8'h00, 8'h00, 1'b0, 1'b0, -1);
        do_div("s_m127_m128", 1'b1, 8'h81,  8'h80, 8'h00, 8'h81, 1'b0, 1'b0, -1);
        do_div("u128_255",    1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, -1);
        do_div("u200_9_poke", 1'b0, 8'd200, 8'd9,  8'd22, 8'd2,  1'b0, 1'b0, 3);
        do_div("s_m7_2_b2b",  1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, -1);
        do_div("s_ovr",       1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, -1);

        // Abort during the fourth CALC cycle; the prior nonzero results must clear.
        signed_mode = 1'b0;
        dividend    = 8'd100;
        divisor     = 8'd7;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_ovr", ovr, 0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        do_div("u20_3_after_rst", 1'b0, 8'd20, 8'd3, 8'd6, 8'd2, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
